imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Loads a program byte stream into instruction memory. A start request
// latches the base address and byte count. It is rejected with a sticky
// error flag when the count is zero or the range runs past the end of memory.
// Once started, each accepted stream byte becomes a byte write one cycle
// later at base + index. A running XOR checksum is kept, and a single done
// pulse is issued together with the final write.
//
// Handshake: a byte moves on every rising edge where byte_valid_i and
// byte_ready_o are both 1. byte_ready_o is 1 exactly while the FSM is in LOAD
// and does not depend on byte_valid_i. The source may hold byte_valid_i low
// for any number of cycles without timing out.
//
// Ports
//   clk_i        : clock, all state changes on the rising edge
//   rst_i        : synchronous active-high reset
//   start_i      : load request, sampled only in IDLE
//   base_addr_i  : first byte address of the load
//   len_i        : number of bytes to load (1..MEM_BYTES)
//   byte_valid_i : source presents a program byte
//   byte_data_i  : program byte
//   byte_ready_o : loader accepts a byte this cycle (state LOAD)
//   wr_en_o      : instruction-memory byte write strobe
//   wr_addr_o    : write address
//   wr_data_o    : write data
//   busy_o       : state is LOAD
//   done_o       : one-cycle completion pulse (state FLUSH)
//   err_o        : sticky range-error flag, cleared by the next start
//   count_o      : bytes accepted in the current/last load
//   csum_o       : XOR of bytes accepted in the current/last load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [9:0]  base_addr_i,
    input  logic [10:0] len_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wr_en_o,
    output logic [9:0]  wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [10:0] count_o,
    output logic [7:0]  csum_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // 12-bit limit so base + len can be formed without any wrap.
    localparam logic [11:0] MEM_LIMIT = 12'(MEM_BYTES);

    state_e      state_q, state_d;
    logic [9:0]  base_q, base_d;
    logic [10:0] len_q, len_d;
    logic [10:0] count_q, count_d;
    logic [7:0]  csum_q, csum_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        wr_en_q, wr_en_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        range_ok;
    logic        accept;
    logic [10:0] count_inc;

    assign range_ok  = (len_i != 11'd0) &&
                       (({2'b00, base_addr_i} + {1'b0, len_i}) <= MEM_LIMIT);
    assign accept    = (state_q == LOAD) && ready_q && byte_valid_i;
    assign count_inc = count_q + 11'd1;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        count_d   = count_q;
        csum_d    = csum_q;
        err_d     = err_q;
        ready_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    len_d   = len_i;
                    count_d = 11'd0;
                    csum_d  = 8'd0;
                    if (range_ok) begin
                        err_d   = 1'b0;
                        state_d = LOAD;
                        ready_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
                if (accept) begin
                    // Address uses the count before this increment.
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + count_q[9:0];
                    wr_data_d = byte_data_i;
                    count_d   = count_inc;
                    csum_d    = csum_q ^ byte_data_i;
                    if (count_inc == len_q) begin
                        // Last byte: FLUSH carries its write and the done pulse.
                        state_d = FLUSH;
                        ready_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // start_i is deliberately not looked at here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            base_q    <= 10'd0;
            len_q     <= 11'd0;
            count_q   <= 11'd0;
            csum_q    <= 8'd0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 10'd0;
            wr_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            count_q   <= count_d;
            csum_q    <= csum_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign count_o      = count_q;
    assign csum_o       = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. A negedge monitor logs every write and done
// pulse (with its cycle number) into got_q; each scenario task builds exp_q
// from hand-computed values and compares inline.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [10:0] len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [9:0]  wr_addr_o;
    logic [7:0]  wr_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [10:0] count_o;
    logic [7:0]  csum_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int se;

    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];
    logic [7:0]  stim[8];

    imem_loader #(.MEM_BYTES(1024)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .count_o(count_o), .csum_o(csum_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    function automatic logic [39:0] wr_ent(int c, logic [9:0] a, logic [7:0] d);
        return {16'(c), 6'h00, a, d};
    endfunction

    function automatic logic [39:0] done_ent(int c);
        return {16'(c), 6'h20, 18'h0};
    endfunction

    always @(negedge clk_i) begin
        if (wr_en_o) got_q.push_back(wr_ent(cyc, wr_addr_o, wr_data_o));
        if (done_o)  got_q.push_back(done_ent(cyc));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drives byte_valid_i from vpat (bit i = cycle i) for ncyc cycles;
    // stim advances only when the DUT accepts.
    task automatic drive_pattern(input logic [15:0] vpat, input int ncyc);
        int k = 0;
        for (int i = 0; i < ncyc; i++) begin
            byte_valid_i = vpat[i];
            byte_data_i  = (k < 8) ? stim[k] : 8'h00;
            if (vpat[i] && byte_ready_o) k++;
            tick();
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic start_load(input logic [9:0] base, input logic [10:0] len);
        got_q.delete();
        exp_q.delete();
        base_addr_i = base;
        len_i       = len;
        start_i     = 1'b1;
        se          = cyc;
        tick();
        start_i     = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; byte_valid_i = 1'b1;
        base_addr_i = 10'd0; len_i = 11'd1; byte_data_i = 8'h5A;
        tick(); tick();
        tests++;
        if ({byte_ready_o, wr_en_o, busy_o, done_o, err_o} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags got %b want 00000",
                     {byte_ready_o, wr_en_o, busy_o, done_o, err_o});
        end
        tests++;
        if ({count_o, csum_o, wr_addr_o, wr_data_o} !== 37'd0) begin
            fails++;
            $display("FAIL reset_values got %h want 0",
                     {count_o, csum_o, wr_addr_o, wr_data_o});
        end
        rst_i = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        stim[0] = 8'h30; stim[1] = 8'hF2; stim[2] = 8'h0A;
        start_load(10'h000, 11'd3);
        tests++;
        if ({busy_o, byte_ready_o} !== 2'b11) begin
            fails++;
            $display("FAIL basic_load_state got %b want 11", {busy_o, byte_ready_o});
        end
        drive_pattern(16'b111, 3);
        tests++;
        if ({done_o, busy_o, byte_ready_o} !== 3'b100) begin
            fails++;
            $display("FAIL basic_flush got %b want 100", {done_o, busy_o, byte_ready_o});
        end
        tick(); tick();
        tests++;
        if (count_o !== 11'd3 || csum_o !== 8'hC8) begin
            fails++;
            $display("FAIL basic_count_csum got %0d/%h want 3/c8", count_o, csum_o);
        end
        exp_q.push_back(wr_ent(se + 2, 10'h000, 8'h30));
        exp_q.push_back(wr_ent(se + 3, 10'h001, 8'hF2));
        exp_q.push_back(wr_ent(se + 4, 10'h002, 8'h0A));
        exp_q.push_back(done_ent(se + 4));
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL basic_events got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL basic_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_top_byte();
        stim[0] = 8'h10;
        start_load(10'h3FF, 11'd1);
        drive_pattern(16'b1, 1);
        tests++;
        if ({done_o, err_o} !== 2'b10) begin
            fails++;
            $display("FAIL top_done_err got %b want 10", {done_o, err_o});
        end
        tick(); tick();
        exp_q.push_back(wr_ent(se + 2, 10'h3FF, 8'h10));
        exp_q.push_back(done_ent(se + 2));
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL top_events got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL top_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_range_err();
        start_load(10'h3FF, 11'd2);
        byte_valid_i = 1'b1;
        byte_data_i  = 8'hEE;
        tests++;
        if ({err_o, busy_o, byte_ready_o} !== 3'b100) begin
            fails++;
            $display("FAIL err_overrun got %b want 100", {err_o, busy_o, byte_ready_o});
        end
        tick(); tick();
        byte_valid_i = 1'b0;
        tests++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL err_no_write got %0d want 0", got_q.size());
        end
        // A good start clears the flag.
        stim[0] = 8'h77;
        start_load(10'h000, 11'd1);
        tests++;
        if ({err_o, busy_o} !== 2'b01) begin
            fails++;
            $display("FAIL err_clear got %b want 01", {err_o, busy_o});
        end
        drive_pattern(16'b1, 1);
        tick();
        tests++;
        if (got_q.size() < 1 || got_q[0] !== wr_ent(se + 2, 10'h000, 8'h77)) begin
            fails++;
            $display("FAIL err_after_write got %h want %h",
                     (got_q.size() > 0) ? got_q[0] : 40'h0, wr_ent(se + 2, 10'h000, 8'h77));
        end
        // Zero length is rejected and clears the count of the last load.
        start_load(10'h005, 11'd0);
        tests++;
        if ({err_o, busy_o} !== 2'b10 || count_o !== 11'd0) begin
            fails++;
            $display("FAIL err_zero_len got %b/%0d want 10/0", {err_o, busy_o}, count_o);
        end
        tick();
    endtask

    task automatic test_gaps();
        stim[0] = 8'hA1; stim[1] = 8'hB2; stim[2] = 8'hC3; stim[3] = 8'hD4;
        start_load(10'h100, 11'd4);
        drive_pattern(16'b1011001, 7);
        tests++;
        if (done_o !== 1'b1) begin
            fails++;
            $display("FAIL gaps_done got %b want 1", done_o);
        end
        tick(); tick();
        tests++;
        if (count_o !== 11'd4 || csum_o !== 8'h04) begin
            fails++;
            $display("FAIL gaps_count_csum got %0d/%h want 4/04", count_o, csum_o);
        end
        exp_q.push_back(wr_ent(se + 2, 10'h100, 8'hA1));
        exp_q.push_back(wr_ent(se + 5, 10'h101, 8'hB2));
        exp_q.push_back(wr_ent(se + 6, 10'h102, 8'hC3));
        exp_q.push_back(wr_ent(se + 8, 10'h103, 8'hD4));
        exp_q.push_back(done_ent(se + 8));
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL gaps_events got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL gaps_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        start_load(10'h200, 11'd8);
        drive_pattern(16'b111, 3);
        tests++;
        if (count_o !== 11'd3) begin
            fails++;
            $display("FAIL abort_precount got %0d want 3", count_o);
        end
        byte_valid_i = 1'b1;
        byte_data_i  = 8'h44;
        rst_i        = 1'b1;
        tick();
        tests++;
        if ({wr_en_o, busy_o, byte_ready_o, done_o} !== 4'b0 || count_o !== 11'd0) begin
            fails++;
            $display("FAIL abort_state got %b/%0d want 0000/0",
                     {wr_en_o, busy_o, byte_ready_o, done_o}, count_o);
        end
        rst_i = 1'b0;
        byte_valid_i = 1'b0;
        tick(); tick();
        exp_q.push_back(wr_ent(se + 2, 10'h200, 8'h11));
        exp_q.push_back(wr_ent(se + 3, 10'h201, 8'h22));
        exp_q.push_back(wr_ent(se + 4, 10'h202, 8'h33));
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL abort_events got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL abort_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_held_start();
        stim[0] = 8'h55; stim[1] = 8'hAA;
        got_q.delete();
        exp_q.delete();
        base_addr_i = 10'h010;
        len_i       = 11'd2;
        start_i     = 1'b1;
        se          = cyc;
        tick();
        drive_pattern(16'b11, 2);
        tests++;
        if ({done_o, busy_o} !== 2'b10) begin
            fails++;
            $display("FAIL held_flush got %b want 10", {done_o, busy_o});
        end
        tick();
        tests++;
        if ({done_o, busy_o} !== 2'b00) begin
            fails++;
            $display("FAIL held_idle got %b want 00", {done_o, busy_o});
        end
        tick();
        start_i = 1'b0;
        tests++;
        if (busy_o !== 1'b1 || count_o !== 11'd0) begin
            fails++;
            $display("FAIL held_restart got %b/%0d want 1/0", busy_o, count_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        exp_q.push_back(wr_ent(se + 2, 10'h010, 8'h55));
        exp_q.push_back(wr_ent(se + 3, 10'h011, 8'hAA));
        exp_q.push_back(done_ent(se + 3));
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL held_events got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL held_ev%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_top_byte();
        test_range_err();
        test_gaps();
        test_reset_abort();
        test_held_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
